// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and interlock-stall unit for the 5-stage pipeline.
// Tracks EX/MEM and MEM/WB destinations itself and counts hazard-stall cycles.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic                      id_ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_regw,
  input  logic                      id_ex_memr,
  input  logic                      mem_ready,
  input  logic                      cnt_clr,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          hazard_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The load flag is not kept for MEM/WB: the register file writes before it
  // reads, so a load there behaves like any other producer.
  logic              em_v_q, em_v_d, em_regw_q, em_regw_d, em_memr_q, em_memr_d;
  logic [REG_AW-1:0] em_rd_q, em_rd_d;
  logic              mw_v_q, mw_v_d, mw_regw_q, mw_regw_d;
  logic [REG_AW-1:0] mw_rd_q, mw_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              x_hit_s, em_hit_s, hz_s;

  function automatic logic dst_match(input logic v, input logic regw,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] r);
    dst_match = v & regw & (rd != {REG_AW{1'b0}}) & (rd == r);
  endfunction

  // Scoreboard advances with the pipeline only when data memory completes.
  always_comb begin
    if (mem_ready) begin
      em_v_d    = id_ex_valid;
      em_rd_d   = id_ex_rd;
      em_regw_d = id_ex_regw;
      em_memr_d = id_ex_memr;
      mw_v_d    = em_v_q;
      mw_rd_d   = em_rd_q;
      mw_regw_d = em_regw_q;
    end else begin
      em_v_d    = em_v_q;
      em_rd_d   = em_rd_q;
      em_regw_d = em_regw_q;
      em_memr_d = em_memr_q;
      mw_v_d    = mw_v_q;
      mw_rd_d   = mw_rd_q;
      mw_regw_d = mw_regw_q;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_v_q    <= 1'b0;
      em_rd_q   <= {REG_AW{1'b0}};
      em_regw_q <= 1'b0;
      em_memr_q <= 1'b0;
      mw_v_q    <= 1'b0;
      mw_rd_q   <= {REG_AW{1'b0}};
      mw_regw_q <= 1'b0;
    end else begin
      em_v_q    <= em_v_d;
      em_rd_q   <= em_rd_d;
      em_regw_q <= em_regw_d;
      em_memr_q <= em_memr_d;
      mw_v_q    <= mw_v_d;
      mw_rd_q   <= mw_rd_d;
      mw_regw_q <= mw_regw_d;
    end
  end

  // EX operand selects; a load still in EX/MEM has no data yet, so it never forwards.
  always_comb begin
    fwd_sel = {(2*NUM_SRC){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((FWD_EN == 1'b1) && !em_memr_q &&
          dst_match(em_v_q, em_regw_q, em_rd_q, id_ex_rs[i*REG_AW +: REG_AW])) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if ((FWD_EN == 1'b1) &&
                   dst_match(mw_v_q, mw_regw_q, mw_rd_q, id_ex_rs[i*REG_AW +: REG_AW])) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end else begin
        fwd_sel[2*i +: 2] = 2'b00;
      end
    end
  end

  // Decode-stage hazard against ID/EX and, without forwarding, EX/MEM too.
  always_comb begin
    x_hit_s  = 1'b0;
    em_hit_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      x_hit_s  = x_hit_s |
                 dst_match(id_ex_valid, id_ex_regw, id_ex_rd, if_id_rs[i*REG_AW +: REG_AW]);
      em_hit_s = em_hit_s |
                 dst_match(em_v_q, em_regw_q, em_rd_q, if_id_rs[i*REG_AW +: REG_AW]);
    end
    if (!if_id_valid) begin
      hz_s = 1'b0;
    end else if (FWD_EN == 1'b1) begin
      hz_s = id_ex_memr & x_hit_s;
    end else begin
      hz_s = x_hit_s | em_hit_s;
    end
  end

  // Memory wait freezes everything and masks any coincident hazard.
  always_comb begin
    if (!mem_ready) begin
      stall  = 1'b1;
      bubble = 1'b0;
    end else if (hz_s) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  // Saturating hazard counter next state; clear wins over increment.
  always_comb begin
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (mem_ready && hz_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hazard counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed pipeline sequences push
// expected outputs; a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid, id_ex_valid, id_ex_regw, id_ex_memr, mem_ready, cnt_clr;
  logic [9:0]  if_id_rs, id_ex_rs;
  logic [4:0]  id_ex_rd;
  logic [3:0]  fwd1, fwd0;
  logic        stall1, bubble1, stall0, bubble0;
  logic [15:0] cnt1, cnt0;

  typedef struct packed {
    logic        which;
    logic [3:0]  fwd;
    logic        st;
    logic        bb;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  m_e, m_got;
  string m_n;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
    .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_regw(id_ex_regw), .id_ex_memr(id_ex_memr), .mem_ready(mem_ready),
    .cnt_clr(cnt_clr), .fwd_sel(fwd1), .stall(stall1), .bubble(bubble1), .hazard_cnt(cnt1)
  );

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u_ilk (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
    .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_regw(id_ex_regw), .id_ex_memr(id_ex_memr), .mem_ready(mem_ready),
    .cnt_clr(cnt_clr), .fwd_sel(fwd0), .stall(stall0), .bubble(bubble0), .hazard_cnt(cnt0)
  );

  function automatic logic [9:0] rs(input int a, input int b);
    logic [4:0] la, lb;
    la = a[4:0];
    lb = b[4:0];
    rs = {lb, la};
  endfunction

  task automatic drv(input logic r, input logic iv, input logic [9:0] irs,
                     input logic ev, input logic [9:0] ers, input logic [4:0] erd,
                     input logic rw, input logic mr, input logic rdy, input logic clr);
    rst_n = r; if_id_valid = iv; if_id_rs = irs;
    id_ex_valid = ev; id_ex_rs = ers; id_ex_rd = erd;
    id_ex_regw = rw; id_ex_memr = mr; mem_ready = rdy; cnt_clr = clr;
  endtask

  task automatic chk(input logic which, input logic [3:0] fwd, input logic st,
                     input logic bb, input logic [15:0] cnt, input string nm);
    exp_t e;
    e.which = which; e.fwd = fwd; e.st = st; e.bb = bb; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drv(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      if (m_e.which) m_got = {1'b1, fwd1, stall1, bubble1, cnt1};
      else           m_got = {1'b0, fwd0, stall0, bubble0, cnt0};
      total = total + 1;
      if (m_got !== m_e) begin
        bad = bad + 1;
        $display("FAIL %s (fwd_en=%0d): got fwd=%b stall=%b bubble=%b cnt=%h, want fwd=%b stall=%b bubble=%b cnt=%h",
                 m_n, m_e.which, m_got.fwd, m_got.st, m_got.bb, m_got.cnt,
                 m_e.fwd, m_e.st, m_e.bb, m_e.cnt);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drv(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "reset_fwd");
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, "reset_ilk");
    tick();
    idle(2);

    // add x5 ; sub x6,x5,x5 back to back
    drv(1'b1, 1'b1, rs(1,2), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t1_c0"); tick();
    drv(1'b1, 1'b1, rs(5,5), 1'b1, rs(1,2), 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t1_c1"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(5,5), 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b1010, 1'b0, 1'b0, 16'd0, "t1_fwd_em"); tick();
    idle(2);

    // add x5 ; xor x9,x1,x2 ; sub x6,x5,x5
    drv(1'b1, 1'b1, rs(1,2), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t1b_c0"); tick();
    drv(1'b1, 1'b1, rs(1,2), 1'b1, rs(1,2), 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t1b_c1"); tick();
    drv(1'b1, 1'b1, rs(5,5), 1'b1, rs(1,2), 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t1b_c2"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(5,5), 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0101, 1'b0, 1'b0, 16'd0, "t1b_fwd_mw"); tick();
    idle(2);

    // lw x7 ; add x8,x7,x1
    drv(1'b1, 1'b1, rs(1,0), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t2_c0"); tick();
    drv(1'b1, 1'b1, rs(7,1), 1'b1, rs(1,0), 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b1, 1'b1, 16'd0, "t2_loaduse"); tick();
    drv(1'b1, 1'b1, rs(7,1), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd1, "t2_after"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(7,1), 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0001, 1'b0, 1'b0, 16'd1, "t2_fwd_mw"); tick();
    idle(2);

    // lw x0 ; add x8,x0,x0
    drv(1'b1, 1'b1, rs(1,0), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd1, "t3_c0"); tick();
    drv(1'b1, 1'b1, rs(0,0), 1'b1, rs(1,0), 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd1, "t3_x0_nostall"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(0,0), 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd1, "t3_x0_nofwd"); tick();
    idle(2);

    // add x5 ; lw x7,(x5) ; add x8,x7,x1 with three memory wait cycles
    drv(1'b1, 1'b1, rs(5,0), 1'b1, rs(1,2), 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd1, "t5_c0"); tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b1, rs(7,1), 1'b1, rs(5,0), 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      chk(1'b1, 4'b0010, 1'b1, 1'b0, 16'd1, "t5_wait_frozen"); tick();
    end
    drv(1'b1, 1'b1, rs(7,1), 1'b1, rs(5,0), 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    chk(1'b1, 4'b0010, 1'b1, 1'b1, 16'd1, "t5_bubble"); tick();
    drv(1'b1, 1'b1, rs(7,1), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd2, "t5_after"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(7,1), 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0001, 1'b0, 1'b0, 16'd2, "t5_fwd_mw"); tick();
    idle(2);

    // Saturation and clear, counter currently 2
    drv(1'b1, 1'b1, rs(7,1), 1'b1, rs(1,0), 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 65533; k++) tick();
    chk(1'b1, 4'b0000, 1'b1, 1'b1, 16'hFFFF, "t6_reach_max"); tick();
    chk(1'b1, 4'b0000, 1'b1, 1'b1, 16'hFFFF, "t6_saturate"); tick();
    drv(1'b1, 1'b1, rs(7,1), 1'b1, rs(1,0), 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    chk(1'b1, 4'b0000, 1'b1, 1'b1, 16'hFFFF, "t6_clr_with_hz"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t6_cleared"); tick();
    idle(2);

    // Interlock-only: addi x3 ; or x4,x3,x2
    drv(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, "t4_rst"); tick();
    idle(1);
    drv(1'b1, 1'b1, rs(1,0), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, "t4_c0"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b1, rs(1,0), 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b1, 1'b1, 16'd0, "t4_d1_s1"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b0, rs(3,2), 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b1, 1'b1, 16'd1, "t4_d1_s2_nofwd"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd2, "t4_d1_go"); tick();
    drv(1'b1, 1'b0, 10'd0, 1'b1, rs(3,2), 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd2, "t4_d1_ex"); tick();
    idle(2);

    // Interlock-only: addi x3 ; xor x9 ; or x4,x3,x2
    drv(1'b1, 1'b1, rs(1,0), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd2, "t4_d2_c0"); tick();
    drv(1'b1, 1'b1, rs(1,2), 1'b1, rs(1,0), 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd2, "t4_d2_c1"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b1, rs(1,2), 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b1, 1'b1, 16'd2, "t4_d2_stall"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd3, "t4_d2_go"); tick();
    idle(2);

    // Reset dropped mid-stall while EX/MEM holds the producer
    drv(1'b1, 1'b1, rs(1,0), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd3, "t7_c0"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b1, rs(1,0), 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b1, 1'b1, 16'd3, "t7_s1"); tick();
    drv(1'b0, 1'b1, rs(3,2), 1'b0, rs(3,2), 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, "t7_async_rst");
    chk(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, "t7_async_rst_fwd"); tick();
    drv(1'b1, 1'b1, rs(3,2), 1'b0, rs(3,2), 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, "t7_post_rst"); tick();
    idle(2);

    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
